// File: rtl/soc_system_pio_mm_master.sv
// Avalon-MM initiator issuing single 32-bit transfers to PIO-style slaves from a valid/ready command port.
// Optional stall timeout is enabled by defining PIO_MM_TIMEOUT_EN.
module soc_system_pio_mm_master #(
  parameter int ADDR_W         = 2,
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  if (READ_LATENCY < 0 || READ_LATENCY > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("soc_system_pio_mm_master: READ_LATENCY must be 0..3 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, RLAT, RESP} state_t;

  localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t     state;
  state_t     state_next;
  logic       accept;
  logic       xfer_done;
  logic       timeout_hit;
  logic       lat_last;
  logic       wsel;
  logic [1:0] lat_cnt;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign xfer_done = (state == XFER) && !avm_waitrequest;
  assign lat_last  = (lat_cnt == LAT_LAST);
  // rsp_write doubles as the stored command direction once a command is accepted
  assign wsel      = (state == IDLE) ? cmd_write : rsp_write;

`ifdef PIO_MM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == XFER) && avm_waitrequest && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      to_cnt    <= '0;
      rsp_error <= 1'b0;
    end else if (state == XFER && avm_waitrequest) begin
      to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) begin
        rsp_error <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (!avm_waitrequest) begin
          if (rsp_write || READ_LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = RLAT;
          end
        end else if (timeout_hit) begin
          state_next = RESP;
        end
      end
      RLAT: begin
        if (lat_last) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they assert exactly for the XFER cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      lat_cnt        <= '0;
    end else begin
      avm_chipselect <= (state_next == XFER);
      avm_write_n    <= !((state_next == XFER) && wsel);
      avm_read_n     <= !((state_next == XFER) && !wsel);

      if (accept) begin
        avm_address   <= cmd_addr;
        avm_writedata <= cmd_wdata;
        rsp_write     <= cmd_write;
        rsp_rdata     <= '0;
      end

      if (xfer_done && !rsp_write && READ_LATENCY == 0) begin
        rsp_rdata <= avm_readdata;
      end

      if (state == RLAT) begin
        lat_cnt <= lat_cnt + 2'd1;
        if (lat_last) begin
          rsp_rdata <= avm_readdata;
        end
      end else begin
        lat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_pio_mm_master.sv
// Directed bench for soc_system_pio_mm_master: cycle table on a zero-latency instance plus
// hand sequences for read latency, stalls/timeout and reset during a transfer.
module tb_soc_system_pio_mm_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, avm_waitrequest = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, avm_readdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_error, avm_chipselect, avm_write_n, avm_read_n;
  logic [31:0] rsp_rdata, avm_writedata;
  logic [1:0]  avm_address;

  logic        b_cmd_valid = 1'b0, b_cmd_write = 1'b0, b_rsp_ready = 1'b0, b_avm_waitrequest = 1'b0;
  logic [1:0]  b_cmd_addr = '0;
  logic [31:0] b_cmd_wdata = '0, b_avm_readdata = '0;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_write, b_rsp_error, b_avm_chipselect, b_avm_write_n, b_avm_read_n;
  logic [31:0] b_rsp_rdata, b_avm_writedata;
  logic [1:0]  b_avm_address;

  soc_system_pio_mm_master #(.ADDR_W(2), .READ_LATENCY(0), .TIMEOUT_CYCLES(4)) u0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_read_n(avm_read_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  soc_system_pio_mm_master #(.ADDR_W(2), .READ_LATENCY(2), .TIMEOUT_CYCLES(255)) u2 (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
    .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
    .avm_address(b_avm_address), .avm_chipselect(b_avm_chipselect), .avm_write_n(b_avm_write_n),
    .avm_read_n(b_avm_read_n), .avm_writedata(b_avm_writedata), .avm_readdata(b_avm_readdata),
    .avm_waitrequest(b_avm_waitrequest)
  );

  typedef struct packed {
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        cs;
    logic        wn;
    logic        rn;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } out_t;

  typedef struct {
    logic        cv;
    logic        cw;
    logic [1:0]  ca;
    logic [31:0] cd;
    logic        rr;
    logic        wr;
    logic [31:0] rd;
    out_t        exp;
  } vec_t;

  out_t act;
  assign act = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
                avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata};

  int checks = 0;
  int errors = 0;
  vec_t vecs[21];
  out_t rst_exp;

  localparam logic [31:0] A = 32'h12345678, C = 32'hCAFEF00D, D = 32'hDEADBEEF;
  localparam logic [31:0] P = 32'hA5A5A5A5, Q = 32'h0F0F0F0F, R = 32'h87654321;

  function automatic vec_t mv(input logic cv, cw, input logic [1:0] ca, input logic [31:0] cd,
                              input logic rr, wr, input logic [31:0] rd,
                              input logic er, ev, ew, input logic [31:0] erd,
                              input logic ecs, ewn, ern, input logic [1:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd; v.rr = rr; v.wr = wr; v.rd = rd;
    v.exp = {er, ev, ew, erd, 1'b0, ecs, ewn, ern, ea, ewd};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, a, e);
    end
  endtask

  task automatic cyc0(input logic cv, cw, input logic [1:0] ca, input logic [31:0] cd,
                      input logic rr, wr, input logic [31:0] rd);
    @(negedge clk);
    cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_wdata = cd;
    rsp_ready = rr; avm_waitrequest = wr; avm_readdata = rd;
    #1;
  endtask

  task automatic cyc2(input logic cv, cw, input logic [1:0] ca, input logic [31:0] cd,
                      input logic rr, wr, input logic [31:0] rd);
    @(negedge clk);
    b_cmd_valid = cv; b_cmd_write = cw; b_cmd_addr = ca; b_cmd_wdata = cd;
    b_rsp_ready = rr; b_avm_waitrequest = wr; b_avm_readdata = rd;
    #1;
  endtask

  initial begin
    int n;
    int bad;
    logic done;

    rst_exp = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0};

    //            cv cw ca cd  rr wr rd            | rdy vld wr rdata cs wn rn addr wdata
    vecs[0]  = mv(1, 1, 0, A, 1, 0, 0,              1, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[1]  = mv(0, 0, 0, 0, 1, 0, 0,              0, 0, 1, 0, 1, 0, 1, 0, A);
    vecs[2]  = mv(1, 0, 0, 0, 1, 1, 0,              0, 1, 1, 0, 0, 1, 1, 0, A);
    vecs[3]  = mv(1, 0, 0, 0, 1, 1, D,              1, 0, 1, 0, 0, 1, 1, 0, A);
    vecs[4]  = mv(0, 0, 0, 0, 1, 1, D,              0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[5]  = mv(0, 0, 0, 0, 1, 1, D,              0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[6]  = mv(0, 0, 0, 0, 1, 1, D,              0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[7]  = mv(0, 0, 0, 0, 1, 0, C,              0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 8; i < 13; i++)
      vecs[i] = mv(1, 1, 2, P, 0, 0, 32'h11111111,  0, 1, 0, C, 0, 1, 1, 0, 0);
    vecs[13] = mv(1, 1, 2, P, 1, 0, 32'h11111111,   0, 1, 0, C, 0, 1, 1, 0, 0);
    vecs[14] = mv(1, 1, 2, P, 1, 0, 0,              1, 0, 0, C, 0, 1, 1, 0, 0);
    vecs[15] = mv(0, 0, 0, 0, 1, 0, 0,              0, 0, 1, 0, 1, 0, 1, 2, P);
    vecs[16] = mv(0, 0, 0, 0, 1, 0, 0,              0, 1, 1, 0, 0, 1, 1, 2, P);
    vecs[17] = mv(1, 0, 3, Q, 1, 0, 0,              1, 0, 1, 0, 0, 1, 1, 2, P);
    vecs[18] = mv(0, 0, 0, 0, 1, 0, R,              0, 0, 0, 0, 1, 1, 0, 3, Q);
    vecs[19] = mv(0, 0, 0, 0, 1, 0, 0,              0, 1, 0, R, 0, 1, 1, 3, Q);
    vecs[20] = mv(0, 0, 0, 0, 1, 0, 0,              1, 0, 0, R, 0, 1, 1, 3, Q);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Zero-latency instance: write, stalled read, held response, write, zero-wait read
    for (int i = 0; i < 21; i++) begin
      cyc0(vecs[i].cv, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].rr, vecs[i].wr, vecs[i].rd);
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // READ_LATENCY=2 instance: read then write
    cyc2(1, 0, 2, 0, 1, 0, 32'h1);
    chk("rl2_idle_ready", {b_cmd_ready, b_rsp_valid, b_avm_chipselect}, 3'b100);
    cyc2(0, 0, 0, 0, 1, 0, 32'h1);
    chk("rl2_strobe", {b_avm_chipselect, b_avm_write_n, b_avm_read_n, b_avm_address}, {3'b110, 2'd2});
    cyc2(0, 0, 0, 0, 1, 0, 32'h2);
    chk("rl2_rlat1", {b_avm_chipselect, b_avm_write_n, b_avm_read_n, b_rsp_valid, b_cmd_ready}, 5'b01100);
    cyc2(0, 0, 0, 0, 1, 0, 32'hBEEF0003);
    chk("rl2_rlat2", {b_avm_chipselect, b_avm_write_n, b_avm_read_n, b_rsp_valid}, 4'b0110);
    cyc2(0, 0, 0, 0, 1, 0, 32'h0);
    chk("rl2_resp", {b_rsp_valid, b_rsp_write, b_rsp_rdata, b_rsp_error}, {2'b10, 32'hBEEF0003, 1'b0});
    cyc2(1, 1, 1, 32'h0BADC0DE, 1, 0, 32'h5);
    chk("rl2_wr_idle", b_cmd_ready, 1'b1);
    cyc2(0, 0, 0, 0, 1, 0, 32'h5);
    chk("rl2_wr_strobe", {b_avm_chipselect, b_avm_write_n, b_avm_read_n, b_avm_writedata}, {3'b101, 32'h0BADC0DE});
    cyc2(0, 0, 0, 0, 1, 0, 32'h5);
    chk("rl2_wr_resp", {b_rsp_valid, b_rsp_write, b_rsp_rdata}, {2'b11, 32'h0});

`ifdef PIO_MM_TIMEOUT_EN
    cyc0(1, 0, 1, 0, 0, 1, 32'h77777777);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc0(0, 0, 1, 0, 0, 1, 32'h77777777);
      if (rsp_valid) begin
        done = 1'b1;
        break;
      end
      if (avm_chipselect) n++;
    end
    chk("timeout_bound", done, 1'b1);
    chk("timeout_strobe_cycles", n, 4);
    chk("timeout_rsp", {rsp_error, rsp_rdata, avm_chipselect, avm_read_n}, {1'b1, 32'h0, 2'b01});
    cyc0(0, 0, 0, 0, 1, 1, 0);
    cyc0(1, 1, 0, 32'h9, 1, 0, 0);
    cyc0(0, 0, 0, 0, 1, 0, 0);
    cyc0(0, 0, 0, 0, 1, 0, 0);
    chk("timeout_err_clears", {rsp_valid, rsp_error}, 2'b10);
`else
    cyc0(1, 0, 1, 0, 0, 1, 0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      cyc0(0, 0, 1, 0, 0, 1, 0);
      if (!(avm_chipselect && !avm_read_n && !rsp_valid && !rsp_error)) bad++;
    end
    chk("stall_hold", bad, 0);
    cyc0(0, 0, 1, 0, 0, 0, 32'h3C3C3C3C);
    cyc0(0, 0, 1, 0, 0, 0, 0);
    chk("stall_resp", {rsp_valid, rsp_error, rsp_rdata, avm_chipselect}, {2'b10, 32'h3C3C3C3C, 1'b0});
    cyc0(0, 0, 0, 0, 1, 0, 0);
`endif

    // Reset while a stalled write is in flight
    cyc0(1, 1, 1, 32'h55, 0, 1, 0);
    cyc0(0, 0, 0, 0, 0, 1, 0);
    chk("rst_pre_xfer", {avm_chipselect, avm_write_n, avm_read_n, avm_address}, {3'b101, 2'd1});
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_still_xfer", {avm_chipselect, rsp_valid}, 2'b10);
    @(negedge clk);
    #1;
    chk("rst_outputs", act, rst_exp);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      cyc0(0, 0, 0, 0, 0, 0, 0);
      if (rsp_valid || !cmd_ready || avm_chipselect) bad++;
    end
    chk("rst_no_response", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
